// File: rtl/motor_mix_seq_pkg.sv
// Shared types and default constants for the quad motor mixer.
// States, motor indices and speed limits used by the sequencer and its datapath.
package quad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRNT,
    S_BCK,
    S_LFT,
    S_RGHT,
    S_COMMIT
  } mix_state_t;

  typedef logic [1:0] motor_idx_t;

  localparam motor_idx_t MOT_FRNT = 2'd0;
  localparam motor_idx_t MOT_BCK  = 2'd1;
  localparam motor_idx_t MOT_LFT  = 2'd2;
  localparam motor_idx_t MOT_RGHT = 2'd3;

  localparam logic [10:0] MIN_RUN_DEF   = 11'h2C0;
  localparam logic [10:0] CAL_SPEED_DEF = 11'h1B0;
  localparam logic [10:0] SPD_MAX_DEF   = 11'h7FF;

endpackage

// File: rtl/motor_mix_seq_if.sv
// PD-term inputs and committed motor-speed outputs of the mixer.
// Master drives sensor side; slave (the mixer) drives speeds and status.
interface motor_mix_seq_if;

  logic        vld;
  logic        inertial_cal;
  logic        clr_ovr;
  logic [8:0]  thrst;
  logic [9:0]  ptch_pterm;
  logic [9:0]  roll_pterm;
  logic [9:0]  yaw_pterm;
  logic [11:0] ptch_dterm;
  logic [11:0] roll_dterm;
  logic [11:0] yaw_dterm;
  logic [10:0] frnt_spd;
  logic [10:0] bck_spd;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        spd_vld;
  logic        busy;
  logic        ovr_run;

  modport master (
    output vld, inertial_cal, clr_ovr, thrst,
    output ptch_pterm, roll_pterm, yaw_pterm,
    output ptch_dterm, roll_dterm, yaw_dterm,
    input  frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy, ovr_run
  );

  modport slave (
    input  vld, inertial_cal, clr_ovr, thrst,
    input  ptch_pterm, roll_pterm, yaw_pterm,
    input  ptch_dterm, roll_dterm, yaw_dterm,
    output frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy, ovr_run
  );

endinterface

// File: rtl/motor_mix_seq_mix_sat.sv
// Combinational base +/- axis +/- yaw adder with 11-bit unsigned clamp.
// Zero latency; no flow control.
module mix_sat #(
  parameter logic [10:0] SPD_MAX = quad_pkg::SPD_MAX_DEF
) (
  input  logic signed [13:0] i_base,
  input  logic signed [13:0] i_axis,
  input  logic signed [13:0] i_yaw,
  input  logic               i_axis_neg,
  input  logic               i_yaw_neg,
  output logic [10:0]        o_spd
);

  logic signed [13:0] w_axis_t;
  logic signed [13:0] w_yaw_t;
  logic signed [13:0] w_sum;

  always_comb begin
    w_axis_t = i_axis_neg ? -i_axis : i_axis;
    w_yaw_t  = i_yaw_neg  ? -i_yaw  : i_yaw;
    w_sum    = i_base + w_axis_t + w_yaw_t;
    if (w_sum < 14'sd0)
      o_spd = '0;
    else if (w_sum > $signed({3'b000, SPD_MAX}))
      o_spd = SPD_MAX;
    else
      o_spd = w_sum[10:0];
  end

endmodule

// File: rtl/motor_mix_seq.sv
// Captures PD terms on vld, mixes one motor per cycle through a shared adder, commits all four.
// vld->spd_vld 5 cycles; vld while busy is dropped and flagged in ovr_run.
module motor_mix_seq
  import quad_pkg::*;
#(
  parameter logic [10:0] MIN_RUN   = MIN_RUN_DEF,
  parameter logic [10:0] CAL_SPEED = CAL_SPEED_DEF,
  parameter logic [10:0] SPD_MAX   = SPD_MAX_DEF
) (
  input logic           clk,
  input logic           rst_n,
  motor_mix_seq_if.slave bus
);

  mix_state_t  r_state;
  mix_state_t  w_next;
  logic [9:0]  r_ptch_p, r_roll_p, r_yaw_p;
  logic [11:0] r_ptch_d, r_roll_d, r_yaw_d;
  logic [8:0]  r_thrst;
  logic        r_cal;
  logic [10:0] r_stg [4];
  logic [10:0] r_frnt, r_bck, r_lft, r_rght;
  logic        r_spd_vld;
  logic        r_ovr_run;

  logic               w_busy, w_capture, w_stg_we, w_commit;
  logic               w_axis_neg, w_yaw_neg;
  motor_idx_t         w_idx;
  logic signed [13:0] w_base, w_ptch, w_roll, w_yaw, w_axis;
  logic [10:0]        w_mix_spd;

  assign w_busy = (r_state != S_IDLE);
  assign w_base = $signed({3'b000, MIN_RUN}) + $signed({5'b00000, r_thrst});
  assign w_ptch = $signed({{4{r_ptch_p[9]}}, r_ptch_p}) + $signed({{2{r_ptch_d[11]}}, r_ptch_d});
  assign w_roll = $signed({{4{r_roll_p[9]}}, r_roll_p}) + $signed({{2{r_roll_d[11]}}, r_roll_d});
  assign w_yaw  = $signed({{4{r_yaw_p[9]}},  r_yaw_p})  + $signed({{2{r_yaw_d[11]}},  r_yaw_d});

  // State selects which motor's operands feed the single shared adder.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_stg_we   = 1'b0;
    w_commit   = 1'b0;
    w_idx      = MOT_FRNT;
    w_axis     = w_ptch;
    w_axis_neg = 1'b0;
    w_yaw_neg  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.vld) begin
          w_capture = 1'b1;
          w_next    = S_FRNT;
        end
      end
      S_FRNT: begin
        w_stg_we   = 1'b1;
        w_axis_neg = 1'b1;
        w_next     = S_BCK;
      end
      S_BCK: begin
        w_stg_we = 1'b1;
        w_idx    = MOT_BCK;
        w_next   = S_LFT;
      end
      S_LFT: begin
        w_stg_we   = 1'b1;
        w_idx      = MOT_LFT;
        w_axis     = w_roll;
        w_axis_neg = 1'b1;
        w_yaw_neg  = 1'b1;
        w_next     = S_RGHT;
      end
      S_RGHT: begin
        w_stg_we  = 1'b1;
        w_idx     = MOT_RGHT;
        w_axis    = w_roll;
        w_yaw_neg = 1'b1;
        w_next    = S_COMMIT;
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  mix_sat #(.SPD_MAX(SPD_MAX)) u_mix_sat (
    .i_base     (w_base),
    .i_axis     (w_axis),
    .i_yaw      (w_yaw),
    .i_axis_neg (w_axis_neg),
    .i_yaw_neg  (w_yaw_neg),
    .o_spd      (w_mix_spd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptch_p  <= '0;
      r_roll_p  <= '0;
      r_yaw_p   <= '0;
      r_ptch_d  <= '0;
      r_roll_d  <= '0;
      r_yaw_d   <= '0;
      r_thrst   <= '0;
      r_cal     <= 1'b0;
      for (int i = 0; i < 4; i++) r_stg[i] <= '0;
      r_frnt    <= '0;
      r_bck     <= '0;
      r_lft     <= '0;
      r_rght    <= '0;
      r_spd_vld <= 1'b0;
      r_ovr_run <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_spd_vld <= w_commit;
      if (w_capture) begin
        r_ptch_p <= bus.ptch_pterm;
        r_roll_p <= bus.roll_pterm;
        r_yaw_p  <= bus.yaw_pterm;
        r_ptch_d <= bus.ptch_dterm;
        r_roll_d <= bus.roll_dterm;
        r_yaw_d  <= bus.yaw_dterm;
        r_thrst  <= bus.thrst;
        r_cal    <= bus.inertial_cal;
      end
      if (w_stg_we)
        r_stg[w_idx] <= r_cal ? CAL_SPEED : w_mix_spd;
      if (w_commit) begin
        r_frnt <= r_stg[MOT_FRNT];
        r_bck  <= r_stg[MOT_BCK];
        r_lft  <= r_stg[MOT_LFT];
        r_rght <= r_stg[MOT_RGHT];
      end
      // Overrun set takes priority over a coincident clear.
      if (bus.vld && w_busy)
        r_ovr_run <= 1'b1;
      else if (bus.clr_ovr)
        r_ovr_run <= 1'b0;
    end
  end

  assign bus.frnt_spd = r_frnt;
  assign bus.bck_spd  = r_bck;
  assign bus.lft_spd  = r_lft;
  assign bus.rght_spd = r_rght;
  assign bus.spd_vld  = r_spd_vld;
  assign bus.busy     = w_busy;
  assign bus.ovr_run  = r_ovr_run;

endmodule

// File: tb/tb_motor_mix_seq.sv
// Scoreboard bench for motor_mix_seq: expected speeds queued on each accepted vld,
// compared when spd_vld pulses.
module tb_motor_mix_seq;

  typedef struct {
    int f;
    int b;
    int l;
    int r;
  } spd_t;

  logic clk;
  logic rst_n;
  motor_mix_seq_if bus ();

  motor_mix_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk;
  int   n_bad;
  spd_t sb[$];
  spd_t last_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int s);
    if (s < 0) return 0;
    if (s > 2047) return 2047;
    return s;
  endfunction

  function automatic spd_t model(input int th, input int pp, input int pd, input int rp,
                                 input int rd, input int yp, input int yd, input bit cal);
    spd_t e;
    int base, p, r, y;
    base = 704 + th;
    p = pp + pd;
    r = rp + rd;
    y = yp + yd;
    if (cal) begin
      e.f = 432; e.b = 432; e.l = 432; e.r = 432;
    end else begin
      e.f = sat(base - p + y);
      e.b = sat(base + p + y);
      e.l = sat(base - r - y);
      e.r = sat(base + r - y);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.spd_vld) begin
      if (sb.size() == 0) begin
        chk("unexp_spd_vld", 1, 0);
      end else begin
        spd_t e;
        e = sb.pop_front();
        chk("frnt", int'(bus.frnt_spd), e.f);
        chk("bck",  int'(bus.bck_spd),  e.b);
        chk("lft",  int'(bus.lft_spd),  e.l);
        chk("rght", int'(bus.rght_spd), e.r);
        last_exp = e;
      end
    end
  end

  // Called at a negedge; drives one vld cycle and returns at the next negedge.
  task automatic send(input int th, input int pp, input int pd, input int rp, input int rd,
                      input int yp, input int yd, input bit cal, input bit expect_accept);
    bus.thrst        = 9'(th);
    bus.ptch_pterm   = 10'(pp);
    bus.ptch_dterm   = 12'(pd);
    bus.roll_pterm   = 10'(rp);
    bus.roll_dterm   = 12'(rd);
    bus.yaw_pterm    = 10'(yp);
    bus.yaw_dterm    = 12'(yd);
    bus.inertial_cal = cal;
    bus.vld          = 1'b1;
    if (expect_accept) sb.push_back(model(th, pp, pd, rp, rd, yp, yd, cal));
    @(negedge clk);
    bus.vld          = 1'b0;
  endtask

  // Waits (bounded) for spd_vld; outputs must hold the last commit meanwhile.
  task automatic wait_spd(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.spd_vld && lat < 20) begin
      if (bus.busy) busy_cnt++;
      chk("hold_frnt", int'(bus.frnt_spd), last_exp.f);
      chk("hold_lft",  int'(bus.lft_spd),  last_exp.l);
      @(negedge clk);
      lat++;
    end
    if (!bus.spd_vld) chk("spd_vld_timeout", 0, 1);
  endtask

  int lat, bc;

  initial begin
    n_chk = 0;
    n_bad = 0;
    last_exp = '{0, 0, 0, 0};
    rst_n = 1'b0;
    bus.vld = 1'b0; bus.inertial_cal = 1'b0; bus.clr_ovr = 1'b0; bus.thrst = '0;
    bus.ptch_pterm = '0; bus.roll_pterm = '0; bus.yaw_pterm = '0;
    bus.ptch_dterm = '0; bus.roll_dterm = '0; bus.yaw_dterm = '0;
    repeat (3) @(negedge clk);
    chk("rst_frnt", int'(bus.frnt_spd), 0);
    chk("rst_rght", int'(bus.rght_spd), 0);
    chk("rst_spd_vld", int'(bus.spd_vld), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovr", int'(bus.ovr_run), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: thrust only
    send(100, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_spd(lat, bc);
    chk("t1_latency", lat, 5);
    chk("t1_busy_cycles", bc, 5);
    @(negedge clk);
    chk("t1_pulse_len", int'(bus.spd_vld), 0);

    // 2: pitch only
    send(0, 50, 20, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_spd(lat, bc);
    chk("t2_latency", lat, 5);
    @(negedge clk);

    // 3: yaw drives both saturation rails
    send(0, 0, 0, 0, 0, -512, -2048, 1'b0, 1'b1);
    wait_spd(lat, bc);
    @(negedge clk);

    // 4: calibration overrides terms
    send(511, 100, -300, -77, 1000, 200, -5, 1'b1, 1'b1);
    wait_spd(lat, bc);
    chk("t4_latency", lat, 5);
    @(negedge clk);

    // Mixed roll/yaw sample with random terms
    begin
      int rp, rd, yp, yd;
      rp = $urandom_range(0, 1023) - 512;
      rd = $urandom_range(0, 4095) - 2048;
      yp = $urandom_range(0, 200) - 100;
      yd = $urandom_range(0, 400) - 200;
      send(37, 0, 0, rp, rd, yp, yd, 1'b0, 1'b1);
      wait_spd(lat, bc);
      @(negedge clk);
    end

    // 5: overrun, sticky flag, coincident accept, clear
    send(200, 0, 0, 30, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    send(5, 400, 400, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("t5_ovr_set", int'(bus.ovr_run), 1);
    wait_spd(lat, bc);
    send(100, 0, 0, 0, 0, 7, 9, 1'b0, 1'b1);
    wait_spd(lat, bc);
    chk("t5_coincident_latency", lat, 5);
    chk("t5_ovr_sticky", int'(bus.ovr_run), 1);
    @(negedge clk);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    chk("t5_ovr_clr", int'(bus.ovr_run), 0);

    // 6: reset mid-sequence aborts without a commit
    send(100, 30, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    last_exp = '{0, 0, 0, 0};
    #1;
    chk("t6_rst_frnt", int'(bus.frnt_spd), 0);
    chk("t6_rst_bck", int'(bus.bck_spd), 0);
    chk("t6_rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t6_idle_busy", int'(bus.busy), 0);
    send(100, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    wait_spd(lat, bc);
    chk("t6_latency", lat, 5);

    repeat (3) @(negedge clk);
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/motor_mix_seq.md
Name: motor_mix_seq

Overview:
Sequencer and mixer that sits downstream of the pitch, roll and yaw PD_math instances. It captures their pterm/dterm outputs on each sensor vld and time-shares one signed adder/saturator across the four motors, one motor per cycle. It then commits all four motor speeds atomically with a single-cycle valid strobe for the ESC interface.

Parameters:
MIN_RUN, 11'h2C0, idle-thrust floor added to every motor (704)
CAL_SPEED, 11'h1B0, fixed speed on all motors while inertial_cal is asserted (432)
SPD_MAX, 11'h7FF, upper saturation limit for motor speeds

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new sensor sample; PD terms valid this cycle
inertial_cal  in  1  calibration mode; sampled with vld
clr_ovr  in  1  synchronous clear of ovr_run
thrst  in  9  unsigned thrust command
ptch_pterm, roll_pterm, yaw_pterm  in  10 each  signed P terms
ptch_dterm, roll_dterm, yaw_dterm  in  12 each  signed D terms
frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  committed unsigned motor speeds
spd_vld  out  1  one-cycle pulse when new speeds are committed
busy  out  1  high from capture until commit
ovr_run  out  1  sticky flag: vld arrived while busy

Behaviour:
- Reset: clk and rst_n as decided; reset is asynchronous, active-low. All speed outputs and staging registers reset to 0. spd_vld=0, busy=0, ovr_run=0, FSM in IDLE.
- FSM states: IDLE, FRNT, BCK, LFT, RGHT, COMMIT.
- IDLE: if vld is high at edge E0, register the six PD terms, thrst and inertial_cal, then go to FRNT. busy goes high after E0.
- FRNT→BCK→LFT→RGHT: one cycle each. At E1..E4, in that order, the corresponding staging register is written.
- COMMIT: at E5 all four outputs load from staging simultaneously, spd_vld is high for the cycle after E5, busy drops after E5, and the FSM returns to IDLE.
- Latency: vld at E0 → spd_vld observed after E5. Outputs hold their previous values until commit.
- Capture may start again in the cycle spd_vld is high: a vld sampled at E6 is accepted.
- Arithmetic: P = sext14(ptch_pterm) + sext14(ptch_dterm); R and Y are formed the same way. base = MIN_RUN + zext(thrst).
  - frnt = base − P + Y
  - bck = base + P + Y
  - lft = base − R − Y
  - rght = base + R − Y
  - All sums are 14-bit signed; no overflow is possible at these widths.
- Saturation: sum < 0 → 0; sum > SPD_MAX → SPD_MAX; otherwise sum[10:0].
- Calibration: if the captured inertial_cal=1, every staging write is CAL_SPEED regardless of terms. The sequence timing is unchanged.
- vld while busy (FRNT..COMMIT): ignored, captured terms are unchanged, and ovr_run is set. ovr_run clears only on clr_ovr or reset; if clr_ovr and an overrun occur together, set wins.
- Reset mid-sequence: FSM returns to IDLE and outputs go to 0. No spd_vld is issued for the aborted sample.
- Only one adder/saturator path exists. The operand mux is driven by the FSM state.

Decomposition:
- Shared package quad_pkg contains:
  - state enum mix_state_t
  - MIN_RUN_DEF, CAL_SPEED_DEF, SPD_MAX_DEF constants
  - motor index typedef
- One sub-module, mix_sat: a combinational 3-operand signed adder plus 11-bit unsigned saturator, instantiated once. It takes base, ±axis and ±yaw via sign-select inputs.

Test Plan:
1. thrst=100, all terms 0, cal=0, vld pulse → after 5 edges all speeds = 11'h324 (804); spd_vld high for exactly 1 cycle; busy high for 5 cycles.
2. thrst=0, ptch_pterm=50, ptch_dterm=20, others 0 → frnt=634, bck=774, lft=rght=704. Previous outputs remain stable until the commit cycle.
3. thrst=0, yaw_pterm=−512, yaw_dterm=12'h800 (−2048) → frnt=bck=0 (negative saturation), lft=rght=2047 (positive saturation).
4. inertial_cal=1 with arbitrary nonzero terms and thrst=511 → all speeds = 432; same 5-edge latency.
5. Second vld 2 cycles after the first → ignored; outputs match the first sample; ovr_run=1 and it stays set. clr_ovr pulse → ovr_run=0. A vld coincident with spd_vld is accepted.
6. rst_n low at E3 of a sequence → outputs 0, busy 0, no spd_vld. After release, a fresh vld with thrst=100 and zero terms → all speeds 804.
